// File: rtl/conv_filter_pkg.sv
// conv_filter_pkg
// Shared types and constants for the 3x3 convolution filter configuration
// controller: frame-tracking FSM states, host register map, the layout of a
// configuration bank and its reset (identity) value, plus small helpers for
// decoding and applying host writes to a bank.
package conv_filter_pkg;

    // Frame tracking states: no frame in progress / inside a frame.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } frame_state_t;

    localparam int CFG_DATA_W = 8;  // host write data width, widest field
    localparam int NUM_TAPS   = 9;  // 3x3 kernel, tap index = row*3+col

    // Host register map: 0-8 kernel taps, then divisor and bias, rest reserved.
    localparam logic [3:0] ADDR_LAST_TAP = 4'd8;
    localparam logic [3:0] ADDR_DIV      = 4'd9;
    localparam logic [3:0] ADDR_BIAS     = 4'd10;

    // One full configuration. Fields are stored at host data width; the
    // narrow fields (taps, divisor) only carry meaning in their low bits.
    typedef struct packed {
        logic [NUM_TAPS-1:0][CFG_DATA_W-1:0] coef;
        logic [CFG_DATA_W-1:0]               div_coef;
        logic [CFG_DATA_W-1:0]               bias;
    } cfg_bank_t;

    // Identity kernel: only the centre tap (index 4) is 1.
    localparam logic [NUM_TAPS-1:0][CFG_DATA_W-1:0] IDENTITY_KERNEL =
        72'h00_00_00_00_01_00_00_00_00;

    localparam cfg_bank_t CFG_RESET_BANK = '{
        coef:     IDENTITY_KERNEL,
        div_coef: 8'd1,
        bias:     8'd0
    };

    function automatic logic addr_reserved(input logic [3:0] addr);
        return addr > ADDR_BIAS;
    endfunction

    // Returns the bank with the addressed field replaced; reserved
    // addresses leave it untouched.
    function automatic cfg_bank_t bank_write(input cfg_bank_t bank,
                                             input logic [3:0] addr,
                                             input logic [CFG_DATA_W-1:0] data);
        cfg_bank_t result;
        result = bank;
        if (addr <= ADDR_LAST_TAP) begin
            result.coef[addr] = data;
        end else if (addr == ADDR_DIV) begin
            result.div_coef = data;
        end else if (addr == ADDR_BIAS) begin
            result.bias = data;
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_pos_tracker.sv
// frame_pos_tracker
// Follows the video stream's line markers to know whether a frame is in
// progress and when it closes.
//   clk, reset   : pixel clock, synchronous active-high reset
//   sop_i, eop_i : line start / line end markers (monitored only)
//   in_frame     : registered, high while a frame is in progress
//   frame_end    : combinational, high on the eop_i that closes the frame
//   fault        : combinational, high on a stray sop_i past the last line
module frame_pos_tracker
    import conv_filter_pkg::*;
#(
    parameter int LINES_PER_FRAME = 720
) (
    input  logic clk,
    input  logic reset,
    input  logic sop_i,
    input  logic eop_i,
    output logic in_frame,
    output logic frame_end,
    output logic fault
);

    // One extra code is needed to park the counter on a stray line.
    localparam int CNT_W = $clog2(LINES_PER_FRAME + 2);
    localparam logic [CNT_W-1:0] LAST_LINE  = CNT_W'(LINES_PER_FRAME);
    localparam logic [CNT_W-1:0] STRAY_LINE = CNT_W'(LINES_PER_FRAME + 1);

    frame_state_t     state_reg, state_next;
    logic [CNT_W-1:0] line_reg, line_next;
    logic             past_last;

    // The counter only leaves zero inside a frame, so this is never true
    // in S_IDLE.
    assign past_last = line_reg >= LAST_LINE;
    assign in_frame  = (state_reg == S_FRAME);
    // A frame that overran (stray sop) still closes on the next eop.
    assign frame_end = in_frame & eop_i & past_last;
    assign fault     = in_frame & sop_i & ~frame_end & past_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            line_reg  <= '0;
        end else begin
            state_reg <= state_next;
            line_reg  <= line_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        if (frame_end) begin
            state_next = S_IDLE;
            line_next  = '0;
        end else if (sop_i) begin
            state_next = S_FRAME;
            line_next  = past_last ? STRAY_LINE : line_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/conv_filter_cfg_ctrl.sv
// conv_filter_cfg_ctrl
// Double-buffered configuration for the 3x3 convolution filter. The host
// fills a shadow bank and requests a commit; the shadow bank is copied to
// the active bank either immediately (no frame in progress) or on the edge
// that closes the current frame, so a frame never sees a mixed kernel.
//   clk, reset         : pixel clock, synchronous active-high reset
//   cfg_wr/addr/wdata  : shadow write port (0-8 taps, 9 divisor, 10 bias)
//   cfg_commit         : request to apply the shadow bank
//   cfg_ready          : writes and commits accepted
//   cfg_pending        : commit armed, waiting for the frame to close
//   cfg_err            : sticky error, cleared by an accepted commit
//   apply_o            : one-cycle pulse when the active bank changes
//   sop_i, eop_i       : stream line markers
//   coef/div_coef/bias_factor : active configuration to the filter
module conv_filter_cfg_ctrl
    import conv_filter_pkg::*;
#(
    parameter int COEF_WIDTH      = 5,
    parameter int LINES_PER_FRAME = 720
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_wr,
    input  logic [3:0]                   cfg_addr,
    input  logic [7:0]                   cfg_wdata,
    input  logic                         cfg_commit,
    output logic                         cfg_ready,
    output logic                         cfg_pending,
    output logic                         cfg_err,
    output logic                         apply_o,
    input  logic                         sop_i,
    input  logic                         eop_i,
    output logic signed [COEF_WIDTH-1:0] coef [3][3],
    output logic signed [COEF_WIDTH-1:0] div_coef,
    output logic [7:0]                   bias_factor
);

    cfg_bank_t shadow_reg, shadow_next;
    cfg_bank_t active_reg, active_next;
    logic      ready_reg, ready_next;
    logic      pending_reg, pending_next;
    logic      err_reg, err_next;
    logic      apply_reg, apply_next;

    logic in_frame, frame_end, fault;
    logic write_ok, write_bad;
    logic commit_ok, div_zero, commit_reject, commit_good;
    logic apply_now, arm_pending, apply_pend, do_apply;
    logic unused_bank_bits;

    frame_pos_tracker #(
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .sop_i     (sop_i),
        .eop_i     (eop_i),
        .in_frame  (in_frame),
        .frame_end (frame_end),
        .fault     (fault)
    );

    assign write_ok  = cfg_wr & ready_reg & ~addr_reserved(cfg_addr);
    assign write_bad = cfg_wr & (~ready_reg | addr_reserved(cfg_addr));

    // A write in the same cycle as the commit must be part of what is
    // committed, so every commit decision looks at shadow_next.
    always_comb begin
        shadow_next = shadow_reg;
        if (write_ok) begin
            shadow_next = bank_write(shadow_reg, cfg_addr, cfg_wdata);
        end
    end

    assign commit_ok     = cfg_commit & ready_reg;
    assign div_zero      = (shadow_next.div_coef[COEF_WIDTH-1:0] == '0);
    assign commit_reject = commit_ok & div_zero;
    assign commit_good   = commit_ok & ~div_zero;
    // Outside a frame the commit lands now, including the cycle carrying
    // the first sop_i, so that frame already uses the new kernel.
    assign apply_now     = commit_good & ~in_frame;
    assign arm_pending   = commit_good & in_frame;
    // While pending, ready is low, so the shadow bank is frozen and the
    // armed value is exactly what gets copied here.
    assign apply_pend    = pending_reg & frame_end;
    assign do_apply      = apply_now | apply_pend;

    always_comb begin
        active_next  = active_reg;
        ready_next   = ready_reg;
        pending_next = pending_reg;
        err_next     = err_reg;
        apply_next   = do_apply;

        if (do_apply) begin
            active_next = shadow_next;
        end

        if (arm_pending) begin
            pending_next = 1'b1;
            ready_next   = 1'b0;
        end else if (apply_pend) begin
            pending_next = 1'b0;
            ready_next   = 1'b1;
        end

        // A fresh error in the same cycle outranks the clear from a commit.
        if (write_bad | commit_reject | fault) begin
            err_next = 1'b1;
        end else if (commit_good) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg  <= CFG_RESET_BANK;
            active_reg  <= CFG_RESET_BANK;
            ready_reg   <= 1'b1;
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
            apply_reg   <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            active_reg  <= active_next;
            ready_reg   <= ready_next;
            pending_reg <= pending_next;
            err_reg     <= err_next;
            apply_reg   <= apply_next;
        end
    end

    assign cfg_ready   = ready_reg;
    assign cfg_pending = pending_reg;
    assign cfg_err     = err_reg;
    assign apply_o     = apply_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            for (gj = 0; gj < 3; gj++) begin : g_col
                assign coef[gi][gj] =
                    $signed(active_reg.coef[gi*3+gj][COEF_WIDTH-1:0]);
            end
        end
    endgenerate

    assign div_coef    = $signed(active_reg.div_coef[COEF_WIDTH-1:0]);
    assign bias_factor = active_reg.bias;

    // Upper bits of the narrow fields have no consumer on the filter side.
    assign unused_bank_bits = ^active_reg;

endmodule

// File: tb/tb_conv_filter_cfg_ctrl.sv
module tb_conv_filter_cfg_ctrl;

    localparam int CW = 5;
    localparam int L  = 720;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_wdata;
    logic          cfg_commit;
    logic          cfg_ready;
    logic          cfg_pending;
    logic          cfg_err;
    logic          apply_o;
    logic          sop_i;
    logic          eop_i;
    logic signed [CW-1:0] coef [3][3];
    logic signed [CW-1:0] div_coef;
    logic [7:0]    bias_factor;

    conv_filter_cfg_ctrl #(
        .COEF_WIDTH      (CW),
        .LINES_PER_FRAME (L)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_ready   (cfg_ready),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err),
        .apply_o     (apply_o),
        .sop_i       (sop_i),
        .eop_i       (eop_i),
        .coef        (coef),
        .div_coef    (div_coef),
        .bias_factor (bias_factor)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Banks are 11 integer fields: 0-8 taps (signed), 9 divisor, 10 bias.
    int m_shadow [11];
    int m_active [11];
    bit m_ready, m_pending, m_err, m_apply;
    bit m_in_frame;
    int m_line;

    function automatic void model_reset();
        for (int i = 0; i < 11; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_shadow[4] = 1; m_active[4] = 1;
        m_shadow[9] = 1; m_active[9] = 1;
        m_ready = 1; m_pending = 0; m_err = 0; m_apply = 0;
        m_in_frame = 0; m_line = 0;
    endfunction

    function automatic void model_step(input bit wr, input logic [3:0] addr,
                                       input logic [7:0] data, input bit commit,
                                       input bit sop, input bit eop);
        bit ready0   = m_ready;
        bit pending0 = m_pending;
        bit frame0   = m_in_frame;
        bit closes   = m_in_frame && eop && (m_line >= L);
        bit err_set  = 0;
        bit err_clr  = 0;
        bit apply    = 0;
        int a        = int'(addr);

        if (wr) begin
            if (!ready0 || a > 10) err_set = 1;
            else if (a == 10)      m_shadow[a] = int'(data);
            else                   m_shadow[a] = int'($signed(data[CW-1:0]));
        end
        if (commit && ready0) begin
            if (m_shadow[9] == 0) err_set = 1;
            else begin
                err_clr = 1;
                if (!frame0) apply = 1;
                else begin m_pending = 1; m_ready = 0; end
            end
        end
        if (pending0 && closes) begin
            apply = 1; m_pending = 0; m_ready = 1;
        end
        if (closes) begin
            m_in_frame = 0; m_line = 0;
        end else if (sop) begin
            if (m_line >= L) begin err_set = 1; m_line = L + 1; end
            else m_line = m_line + 1;
            m_in_frame = 1;
        end
        if (apply) m_active = m_shadow;
        if (err_set)      m_err = 1;
        else if (err_clr) m_err = 0;
        m_apply = apply;
    endfunction

    function automatic logic [63:0] model_pack();
        logic [63:0] p = '0;
        int v;
        for (int i = 0; i < 10; i++) begin
            v = m_active[i];
            p[i*CW +: CW] = v[CW-1:0];
        end
        v = m_active[10];
        p[10*CW +: 8] = v[7:0];
        return p;
    endfunction

    function automatic logic [63:0] dut_pack();
        logic [63:0] p = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[(r*3+c)*CW +: CW] = coef[r][c];
        p[9*CW +: CW] = div_coef;
        p[10*CW +: 8] = bias_factor;
        return p;
    endfunction

    // ---------------- stimulus ----------------
    bit rnd_en = 0;

    task automatic step(input bit wr, input logic [3:0] addr, input logic [7:0] data,
                        input bit commit, input bit sop, input bit eop);
        cfg_wr = wr; cfg_addr = addr; cfg_wdata = data; cfg_commit = commit;
        sop_i = sop; eop_i = eop;
        model_step(wr, addr, data, commit, sop, eop);
        @(posedge clk);
        #1;
        check("flags", {60'd0, cfg_ready, cfg_pending, cfg_err, apply_o},
                       {60'd0, m_ready, m_pending, m_err, m_apply});
        check("active", dut_pack(), model_pack());
        if (wr || commit || apply_o)
            $display("t=%0t wr=%0d addr=%0d data=%h commit=%0d sop=%0d eop=%0d -> ready=%0d pending=%0d err=%0d apply=%0d",
                     $time, wr, addr, data, commit, sop, eop, cfg_ready, cfg_pending, cfg_err, apply_o);
        cfg_wr = 0; cfg_commit = 0; sop_i = 0; eop_i = 0;
    endtask

    // Step with random host traffic when randomisation is enabled.
    task automatic rstep(input bit sop, input bit eop);
        bit wr = 0, cm = 0;
        logic [3:0] a = '0;
        logic [7:0] d = '0;
        if (rnd_en) begin
            wr = ($urandom_range(0, 7) == 0);
            a  = 4'($urandom_range(0, 11));
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0 && a == 4'd9) d[CW-1:0] = '0;
            cm = ($urandom_range(0, 63) == 0);
        end
        step(wr, a, d, cm, sop, eop);
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) begin
            rstep(1, 0);
            if (rnd_en) repeat ($urandom_range(0, 1)) rstep(0, 0);
            rstep(0, 1);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        cfg_wr = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0; sop_i = 0; eop_i = 0;
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        check("rst_flags", {60'd0, cfg_ready, cfg_pending, cfg_err, apply_o}, 64'h8);
        check("rst_active", dut_pack(), model_pack());
    endtask

    initial begin
        do_reset();
        check("rst_coef11", 64'(int'(coef[1][1])), 64'd1);
        check("rst_div", 64'(int'(div_coef)), 64'd1);

        // Divisor zero commit is rejected.
        step(1, 4'd9, 8'h00, 0, 0, 0);
        step(0, 4'd0, 8'h00, 1, 0, 0);
        check("div0_err", 64'(cfg_err), 64'd1);
        check("div0_noapply", 64'(apply_o), 64'd0);
        check("div0_div", 64'(int'(div_coef)), 64'd1);

        // Immediate apply in idle; also clears the error.
        step(1, 4'd0, 8'hFE, 0, 0, 0);
        step(1, 4'd9, 8'd4, 0, 0, 0);
        step(1, 4'd10, 8'd16, 0, 0, 0);
        step(0, 4'd0, 8'h00, 1, 0, 0);
        check("imm_apply", 64'(apply_o), 64'd1);
        check("imm_coef00", 64'(int'(coef[0][0])), 64'(-2));
        check("imm_div", 64'(int'(div_coef)), 64'd4);
        check("imm_bias", 64'(bias_factor), 64'd16);
        check("imm_err_clr", 64'(cfg_err), 64'd0);

        // Commit mid-frame on line 300, write while pending is dropped.
        run_lines(299);
        step(0, 4'd0, 8'h00, 0, 1, 0);
        step(1, 4'd10, 8'd99, 0, 0, 0);
        step(0, 4'd0, 8'h00, 1, 0, 0);
        check("pend_set", {62'd0, cfg_pending, cfg_ready}, 64'h2);
        step(1, 4'd10, 8'd55, 0, 0, 0);
        check("pend_wr_err", 64'(cfg_err), 64'd1);
        step(0, 4'd0, 8'h00, 0, 0, 1);
        run_lines(419);
        step(0, 4'd0, 8'h00, 0, 1, 0);
        check("pend_hold", 64'(bias_factor), 64'd16);
        step(0, 4'd0, 8'h00, 0, 0, 1);
        check("pend_apply", {61'd0, apply_o, cfg_ready, cfg_pending}, 64'h6);
        check("pend_bias", 64'(bias_factor), 64'd99);

        // Reset while pending mid-frame.
        run_lines(5);
        step(1, 4'd10, 8'd77, 1, 0, 0);
        run_lines(4);
        do_reset();
        check("rstp_pending", 64'(cfg_pending), 64'd0);
        check("rstp_bias", 64'(bias_factor), 64'd0);

        // Commit coincident with the first sop after reset.
        step(1, 4'd8, 8'd5, 0, 0, 0);
        step(0, 4'd0, 8'h00, 1, 1, 0);
        check("sop_apply", 64'(apply_o), 64'd1);
        check("sop_coef22", 64'(int'(coef[2][2])), 64'd5);
        step(0, 4'd0, 8'h00, 0, 0, 1);
        run_lines(718);
        step(0, 4'd0, 8'h00, 0, 1, 0);
        step(0, 4'd0, 8'h00, 0, 0, 1);
        check("sop_no_apply", 64'(apply_o), 64'd0);

        // Stray sop past the last line with a pending commit.
        run_lines(4);
        step(1, 4'd10, 8'd33, 1, 0, 0);
        run_lines(715);
        step(0, 4'd0, 8'h00, 0, 1, 0);
        check("stray_err_pre", 64'(cfg_err), 64'd0);
        step(0, 4'd0, 8'h00, 0, 1, 0);
        check("stray_err", 64'(cfg_err), 64'd1);
        check("stray_hold", 64'(bias_factor), 64'd0);
        step(0, 4'd0, 8'h00, 0, 0, 1);
        check("stray_apply", 64'(apply_o), 64'd1);
        check("stray_bias", 64'(bias_factor), 64'd33);

        // Randomised traffic over several frames.
        rnd_en = 1;
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) rstep(0, 0);
            run_lines(L - 1);
            rstep(1, 0);
            if ($urandom_range(0, 3) == 0) rstep(1, 0);
            rstep(0, 1);
        end
        repeat (4) rstep(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
